// File: rtl/matrix_pkg.sv
// ---- matrix_pkg : shared element width, address width, opcode and FSM encodings
// ---- Rev 1.0
`default_nettype none

package matrix_pkg;

    localparam int ELEMENT_WIDTH   = 8;
    localparam int BRAM_ADDR_WIDTH = 10;

    typedef enum logic [1:0] {
        OP_ADD = 2'd0,
        OP_SUB = 2'd1,
        OP_HAD = 2'd2,
        OP_SCL = 2'd3
    } op_e;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_RD1  = 3'd1,
        S_W1   = 3'd2,
        S_RD2  = 3'd3,
        S_W2   = 3'd4,
        S_WR   = 3'd5,
        S_NEXT = 3'd6,
        S_DONE = 3'd7
    } state_e;

endpackage

`default_nettype wire

// File: rtl/matrix_elem_alu.sv
// ---- matrix_elem_alu : signed element add/sub/multiply with optional saturation
// ---- Rev 1.0
`default_nettype none

module matrix_elem_alu
    import matrix_pkg::*;
#(
    parameter int ELEMENT_WIDTH = matrix_pkg::ELEMENT_WIDTH
) (
    input  logic signed [ELEMENT_WIDTH-1:0] a,
    input  logic signed [ELEMENT_WIDTH-1:0] b,
    input  logic        [1:0]               mode,
    input  logic                            saturate,
    output logic signed [ELEMENT_WIDTH-1:0] result,
    output logic                            ovf
);

    localparam int W = ELEMENT_WIDTH;
    localparam logic [W-1:0] MAXV = {1'b0, {(W-1){1'b1}}};
    localparam logic [W-1:0] MINV = {1'b1, {(W-1){1'b0}}};

    logic [W:0]     sum;
    logic [2*W-1:0] prod;
    logic           hi_neg;

    always_comb begin
        sum    = '0;
        prod   = '0;
        hi_neg = 1'b0;
        result = '0;
        ovf    = 1'b0;
        if (mode == OP_ADD || mode == OP_SUB) begin
            sum    = (mode == OP_SUB) ? ({a[W-1], a} - {b[W-1], b})
                                      : ({a[W-1], a} + {b[W-1], b});
            ovf    = sum[W] ^ sum[W-1];
            hi_neg = sum[W];
            result = sum[W-1:0];
        end else begin
            prod   = a * b;
            // In range only if the top W+1 bits are all copies of the sign
            ovf    = (prod[2*W-1:W-1] != {(W+1){prod[2*W-1]}});
            hi_neg = prod[2*W-1];
            result = prod[W-1:0];
        end
        if (ovf && saturate) begin
            result = hi_neg ? MINV : MAXV;
        end
    end

endmodule

`default_nettype wire

// File: rtl/matrix_op_elementwise.sv
// ---- matrix_op_elementwise : element-wise add/sub/Hadamard/scalar-multiply over BRAM matrices
// ---- Rev 1.0
`default_nettype none

module matrix_op_elementwise
    import matrix_pkg::*;
#(
    parameter int ELEMENT_WIDTH = matrix_pkg::ELEMENT_WIDTH,
    parameter int ADDR_WIDTH    = matrix_pkg::BRAM_ADDR_WIDTH,
    parameter int DIM_WIDTH     = 5,
    parameter int RD_LATENCY    = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic [1:0]               mode,
    input  logic                     saturate,
    input  logic [ELEMENT_WIDTH-1:0] scalar,
    input  logic [DIM_WIDTH-1:0]     dim_m,
    input  logic [DIM_WIDTH-1:0]     dim_n,
    input  logic [ADDR_WIDTH-1:0]    addr_op1,
    input  logic [ADDR_WIDTH-1:0]    addr_op2,
    input  logic [ADDR_WIDTH-1:0]    addr_res,
    output logic                     busy,
    output logic                     done,
    output logic                     error,
    output logic                     ovf,
    output logic                     mem_rd_en,
    output logic [ADDR_WIDTH-1:0]    mem_rd_addr,
    input  logic [ELEMENT_WIDTH-1:0] mem_rd_data,
    output logic                     mem_wr_en,
    output logic [ADDR_WIDTH-1:0]    mem_wr_addr,
    output logic [ELEMENT_WIDTH-1:0] mem_wr_data
);

    localparam logic [2:0] LAT_LAST = 3'(RD_LATENCY - 1);

    state_e                   state_q, state_d;
    op_e                      mode_q;
    logic                     sat_q;
    logic [ELEMENT_WIDTH-1:0] scalar_q, op1_q, op2_q;
    logic [DIM_WIDTH-1:0]     dim_m_q, dim_n_q, i_q, j_q;
    logic [ADDR_WIDTH-1:0]    base1_q, base2_q, baser_q, off_q;
    logic [2:0]               cnt_q;
    logic                     error_q, ovf_q;

    logic                     w_dim_zero, w_last_j, w_last_i, w_wait_end;
    logic [ELEMENT_WIDTH-1:0] w_alu_b, w_alu_res;
    logic                     w_alu_ovf;

    assign w_dim_zero = (dim_m == '0) || (dim_n == '0);
    assign w_last_j   = (j_q == dim_n_q - DIM_WIDTH'(1));
    assign w_last_i   = (i_q == dim_m_q - DIM_WIDTH'(1));
    assign w_wait_end = (cnt_q == LAT_LAST);
    assign w_alu_b    = (mode_q == OP_SCL) ? scalar_q : op2_q;

    matrix_elem_alu #(
        .ELEMENT_WIDTH(ELEMENT_WIDTH)
    ) u_alu (
        .a        (op1_q),
        .b        (w_alu_b),
        .mode     (mode_q),
        .saturate (sat_q),
        .result   (w_alu_res),
        .ovf      (w_alu_ovf)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            mode_q   <= OP_ADD;
            sat_q    <= 1'b0;
            scalar_q <= '0;
            op1_q    <= '0;
            op2_q    <= '0;
            dim_m_q  <= '0;
            dim_n_q  <= '0;
            i_q      <= '0;
            j_q      <= '0;
            base1_q  <= '0;
            base2_q  <= '0;
            baser_q  <= '0;
            off_q    <= '0;
            cnt_q    <= '0;
            error_q  <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            case (state_q)
                S_IDLE: if (start) begin
                    mode_q   <= op_e'(mode);
                    sat_q    <= saturate;
                    scalar_q <= scalar;
                    dim_m_q  <= dim_m;
                    dim_n_q  <= dim_n;
                    base1_q  <= addr_op1;
                    base2_q  <= addr_op2;
                    baser_q  <= addr_res;
                    i_q      <= '0;
                    j_q      <= '0;
                    off_q    <= '0;
                    cnt_q    <= '0;
                    error_q  <= w_dim_zero;
                    ovf_q    <= 1'b0;
                end
                S_W1: begin
                    cnt_q <= w_wait_end ? 3'd0 : cnt_q + 3'd1;
                    if (w_wait_end) op1_q <= mem_rd_data;
                end
                S_W2: begin
                    cnt_q <= w_wait_end ? 3'd0 : cnt_q + 3'd1;
                    if (w_wait_end) op2_q <= mem_rd_data;
                end
                S_WR:   ovf_q <= ovf_q | w_alu_ovf;
                S_NEXT: begin
                    off_q <= off_q + ADDR_WIDTH'(1);
                    if (w_last_j) begin
                        j_q <= '0;
                        i_q <= i_q + DIM_WIDTH'(1);
                    end else begin
                        j_q <= j_q + DIM_WIDTH'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        state_d     = state_q;
        mem_rd_en   = 1'b0;
        mem_rd_addr = '0;
        mem_wr_en   = 1'b0;
        mem_wr_addr = '0;
        mem_wr_data = '0;
        case (state_q)
            S_IDLE: if (start) state_d = w_dim_zero ? S_DONE : S_RD1;
            S_RD1: begin
                mem_rd_en   = 1'b1;
                mem_rd_addr = base1_q + off_q;
                state_d     = S_W1;
            end
            S_W1: if (w_wait_end) state_d = (mode_q == OP_SCL) ? S_WR : S_RD2;
            S_RD2: begin
                mem_rd_en   = 1'b1;
                mem_rd_addr = base2_q + off_q;
                state_d     = S_W2;
            end
            S_W2: if (w_wait_end) state_d = S_WR;
            S_WR: begin
                mem_wr_en   = 1'b1;
                mem_wr_addr = baser_q + off_q;
                mem_wr_data = w_alu_res;
                state_d     = S_NEXT;
            end
            S_NEXT: state_d = (w_last_j && w_last_i) ? S_DONE : S_RD1;
            S_DONE: if (!start) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    assign busy  = (state_q != S_IDLE) && (state_q != S_DONE);
    assign done  = (state_q == S_DONE);
    assign error = error_q;
    assign ovf   = ovf_q;

endmodule

`default_nettype wire

// File: tb/tb_matrix_op_elementwise.sv
// ---- tb_matrix_op_elementwise : directed vector table plus reset, zero-dim and 16x16 sequences
// ---- Rev 1.0
`default_nettype none

module tb_matrix_op_elementwise;

    localparam int L = 2;

    logic       clk, rst_n, start, saturate, busy, done, error, ovf;
    logic       mem_rd_en, mem_wr_en;
    logic [1:0] mode;
    logic [7:0] scalar, mem_rd_data, mem_wr_data;
    logic [4:0] dim_m, dim_n;
    logic [9:0] addr_op1, addr_op2, addr_res, mem_rd_addr, mem_wr_addr;

    matrix_op_elementwise #(
        .ELEMENT_WIDTH(8), .ADDR_WIDTH(10), .DIM_WIDTH(5), .RD_LATENCY(L)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .mode(mode), .saturate(saturate),
        .scalar(scalar), .dim_m(dim_m), .dim_n(dim_n), .addr_op1(addr_op1),
        .addr_op2(addr_op2), .addr_res(addr_res), .busy(busy), .done(done),
        .error(error), .ovf(ovf), .mem_rd_en(mem_rd_en), .mem_rd_addr(mem_rd_addr),
        .mem_rd_data(mem_rd_data), .mem_wr_en(mem_wr_en), .mem_wr_addr(mem_wr_addr),
        .mem_wr_data(mem_wr_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [7:0]  mem [1024];
    logic [7:0]  pipe [L];
    logic [17:0] wr_log [$];
    int          rd_cnt = 0, rd2_cnt = 0, both_cnt = 0;
    int          total = 0, bad = 0;

    assign mem_rd_data = pipe[L-1];

    always @(posedge clk) begin
        pipe[0] <= mem_rd_en ? mem[mem_rd_addr] : 8'hEE;
        for (int s = 1; s < L; s++) pipe[s] <= pipe[s-1];
        if (mem_rd_en) rd_cnt <= rd_cnt + 1;
        if (mem_rd_en && mem_rd_addr[9:8] == 2'b01) rd2_cnt <= rd2_cnt + 1;
        if (mem_rd_en && mem_wr_en) both_cnt <= both_cnt + 1;
        if (mem_wr_en) wr_log.push_back({mem_wr_addr, mem_wr_data});
    end

    typedef struct {
        logic [1:0]      mode;
        logic            sat;
        logic [7:0]      scalar;
        int              m;
        int              n;
        logic [7:0][7:0] a;
        logic [7:0][7:0] b;
        logic [7:0][7:0] e;
        logic            ovf;
    } vec_t;

    vec_t vt [9];

    function automatic logic [7:0][7:0] p8(input int v0 = 0, input int v1 = 0,
                                           input int v2 = 0, input int v3 = 0,
                                           input int v4 = 0, input int v5 = 0);
        logic [7:0][7:0] r;
        r = '0;
        r[0] = v0[7:0]; r[1] = v1[7:0]; r[2] = v2[7:0];
        r[3] = v3[7:0]; r[4] = v4[7:0]; r[5] = v5[7:0];
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic set_ops(input logic [1:0] md, input logic sat, input logic [7:0] sc,
                           input int m, input int n);
        mode = md; saturate = sat; scalar = sc;
        dim_m = 5'(m); dim_n = 5'(n);
        addr_op1 = 10'h000; addr_op2 = 10'h100; addr_res = 10'h200;
    endtask

    // Raises start, scrambles all operands after acceptance, waits for done
    task automatic go_wait(input logic [1:0] md, input logic sat, input int budget,
                           output int cyc);
        start = 1'b1;
        cyc = 0;
        while (cyc < budget) begin
            @(posedge clk); #1;
            cyc++;
            if (cyc == 1) begin
                mode = ~md; saturate = ~sat; scalar = 8'h55;
                dim_m = 5'd0; dim_n = 5'd0;
                addr_op1 = 10'h3C0; addr_op2 = 10'h3D0; addr_res = 10'h3E0;
            end
            if (done) break;
        end
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        int n, cyc, wbase, r2base, misorder, exp_lat;
        n = v.m * v.n;
        for (int k = 0; k < n; k++) begin
            mem[k] = v.a[k];
            mem[10'h100 + k] = v.b[k];
        end
        wbase = wr_log.size();
        r2base = rd2_cnt;
        set_ops(v.mode, v.sat, v.scalar, v.m, v.n);
        go_wait(v.mode, v.sat, 5000, cyc);
        exp_lat = (v.mode == 2'd3) ? n * (L + 3) + 1 : n * (2 * (L + 1) + 2) + 1;
        check($sformatf("v%0d_done", idx), done, 1);
        check($sformatf("v%0d_latency", idx), cyc, exp_lat);
        check($sformatf("v%0d_wr_count", idx), wr_log.size() - wbase, n);
        misorder = 0;
        for (int k = 0; k < n && wbase + k < wr_log.size(); k++) begin
            if (wr_log[wbase + k][17:8] != 10'(10'h200 + k)) misorder++;
            check($sformatf("v%0d_res%0d", idx, k), wr_log[wbase + k][7:0], v.e[k]);
        end
        check($sformatf("v%0d_wr_order", idx), misorder, 0);
        check($sformatf("v%0d_ovf", idx), ovf, v.ovf);
        check($sformatf("v%0d_error", idx), error, 0);
        if (v.mode == 2'd3) check($sformatf("v%0d_op2_reads", idx), rd2_cnt - r2base, 0);
        start = 1'b0;
        @(posedge clk); #1;
        check($sformatf("v%0d_done_clear", idx), done, 0);
    endtask

    initial begin
        int cyc, rbase, wbase, bad_res;
        vt[0] = '{2'd0, 1'b0, 8'd0, 2, 3, p8(1, 2, 3, 4, 5, 6), p8(10, 20, 30, 40, 50, 60),
                  p8(11, 22, 33, 44, 55, 66), 1'b0};
        vt[1] = '{2'd1, 1'b1, 8'd0, 1, 1, p8(-100), p8(100), p8(-128), 1'b1};
        vt[2] = '{2'd1, 1'b0, 8'd0, 1, 1, p8(-100), p8(100), p8(56), 1'b1};
        vt[3] = '{2'd3, 1'b1, 8'd3, 1, 4, p8(10, -5, 50, -50), p8(), p8(30, -15, 127, -128), 1'b1};
        vt[4] = '{2'd2, 1'b1, 8'd0, 2, 2, p8(3, -4, 20, -16), p8(5, 6, 7, 8),
                  p8(15, -24, 127, -128), 1'b1};
        vt[5] = '{2'd2, 1'b0, 8'd0, 1, 2, p8(16, -3), p8(16, 5), p8(0, -15), 1'b1};
        vt[6] = '{2'd0, 1'b1, 8'd0, 1, 2, p8(100, -100), p8(27, -28), p8(127, -128), 1'b0};
        vt[7] = '{2'd0, 1'b1, 8'd0, 1, 1, p8(100), p8(28), p8(127), 1'b1};
        vt[8] = '{2'd3, 1'b0, 8'hFF, 1, 2, p8(-128, 5), p8(), p8(-128, -5), 1'b1};

        rst_n = 1'b0; start = 1'b0;
        set_ops(2'd0, 1'b0, 8'd0, 0, 0);
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_flags", {error, ovf, mem_rd_en, mem_wr_en}, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Zero dimension: straight to DONE with error and no memory traffic
        rbase = rd_cnt; wbase = wr_log.size();
        set_ops(2'd0, 1'b0, 8'd0, 3, 0);
        go_wait(2'd0, 1'b0, 2, cyc);
        check("zdim_done", done, 1);
        check("zdim_error", error, 1);
        check("zdim_mem", (rd_cnt - rbase) + (wr_log.size() - wbase), 0);
        start = 1'b0;
        @(posedge clk); #1;

        for (int i = 0; i < 9; i++) run_vec(vt[i], i);

        // Async reset during W2 of element 2 (cycle 2*8+4 after acceptance)
        for (int k = 0; k < 6; k++) begin
            mem[k] = vt[0].a[k];
            mem[10'h100 + k] = vt[0].b[k];
        end
        set_ops(2'd1, 1'b1, 8'd0, 2, 3);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        check("prerst_busy", busy, 1);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_outs", {busy, done, error, ovf, mem_rd_en, mem_wr_en}, 0);
        check("midrst_bus", {mem_rd_addr, mem_wr_addr, mem_wr_data}, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        run_vec(vt[0], 100);

        // 16x16 add, then hold start to confirm no restart
        for (int k = 0; k < 256; k++) begin
            mem[k] = 8'(k % 64);
            mem[10'h100 + k] = 8'((k % 50) - 25);
        end
        wbase = wr_log.size();
        set_ops(2'd0, 1'b1, 8'd0, 16, 16);
        go_wait(2'd0, 1'b1, 5000, cyc);
        check("big_latency", cyc, 256 * (2 * (L + 1) + 2) + 1);
        check("big_wr_count", wr_log.size() - wbase, 256);
        bad_res = 0;
        for (int k = 0; k < 256 && wbase + k < wr_log.size(); k++) begin
            if (wr_log[wbase + k] != {10'(10'h200 + k), 8'((k % 64) + (k % 50) - 25)})
                bad_res++;
        end
        check("big_results", bad_res, 0);
        check("big_ovf", ovf, 0);
        rbase = rd_cnt;
        repeat (10) @(posedge clk);
        #1;
        check("hold_done", done, 1);
        check("hold_busy", busy, 0);
        check("hold_no_reads", rd_cnt - rbase, 0);
        start = 1'b0;
        @(posedge clk); #1;
        check("hold_release", done, 0);
        check("rd_wr_exclusive", both_cnt, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
